// File: rtl/store_checker.sv
// End-of-test monitor on the CPU data-memory write bus: classifies stores into a
// sticky pass/fail/timeout verdict and keeps a show-ahead FIFO log of store traffic.
module store_checker #(
    parameter logic [31:0] PASS_ADDR  = 32'd84,
    parameter logic [31:0] PASS_DATA  = 32'd7,
    parameter logic [31:0] ALLOW_ADDR = 32'd80,
    parameter int          TIMEOUT    = 1024,
    parameter int          LOG_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [15:0] store_cnt,
    output logic [31:0] fail_adr,
    output logic [31:0] fail_data,
    input  logic        log_rd,
    output logic        log_valid,
    output logic [31:0] log_adr,
    output logic [31:0] log_data,
    output logic        log_ovf
);

    localparam int CW = $clog2(TIMEOUT);
    localparam int AW = $clog2(LOG_DEPTH);
    localparam logic [CW-1:0] CYC_LAST = CW'(TIMEOUT - 1);
    localparam logic [AW:0]   LOG_FULL = (AW + 1)'(LOG_DEPTH);

    typedef enum logic [1:0] {
        S_RUN,
        S_PASS,
        S_FAIL,
        S_TMO
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cyc_q, cyc_d;
    logic            store_hit;
    logic            illegal;

    logic [31:0]     mem_adr  [LOG_DEPTH];
    logic [31:0]     mem_data [LOG_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     log_count;
    logic            log_full;
    logic            push, pop, push_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RUN;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
        end
    end

    // A store on the timeout edge is classified first, so it beats the timeout.
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        store_hit = 1'b0;
        illegal   = 1'b0;
        if (clr) begin
            state_d = S_RUN;
            cyc_d   = '0;
        end else if (state_q == S_RUN) begin
            store_hit = memwrite;
            if (memwrite && dataadr == PASS_ADDR && writedata == PASS_DATA) begin
                state_d = S_PASS;
            end else if (memwrite && dataadr != ALLOW_ADDR) begin
                state_d = S_FAIL;
                illegal = 1'b1;
            end else if (cyc_q == CYC_LAST) begin
                state_d = S_TMO;
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            store_cnt <= '0;
            fail_adr  <= '0;
            fail_data <= '0;
        end else if (clr) begin
            store_cnt <= '0;
            fail_adr  <= '0;
            fail_data <= '0;
        end else begin
            if (store_hit && store_cnt != 16'hFFFF)
                store_cnt <= store_cnt + 16'd1;
            if (illegal) begin
                fail_adr  <= dataadr;
                fail_data <= writedata;
            end
        end
    end

    assign done    = (state_q != S_RUN);
    assign pass    = (state_q == S_PASS);
    assign fail    = (state_q == S_FAIL);
    assign timeout = (state_q == S_TMO);

    // A pop on a full log frees a slot in the same edge, so the push still lands.
    assign log_full = (log_count == LOG_FULL);
    assign push     = store_hit;
    assign pop      = log_rd && (log_count != '0) && !clr;
    assign push_ok  = push && (!log_full || pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            log_count <= '0;
            log_ovf   <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            log_count <= '0;
            log_ovf   <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop)
                log_count <= log_count + 1'b1;
            else if (pop && !push_ok)
                log_count <= log_count - 1'b1;
            if (push && !push_ok)
                log_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_adr[wr_ptr]  <= dataadr;
            mem_data[wr_ptr] <= writedata;
        end
    end

    assign log_valid = (log_count != '0);
    assign log_adr   = log_valid ? mem_adr[rd_ptr]  : '0;
    assign log_data  = log_valid ? mem_data[rd_ptr] : '0;

endmodule

// File: tb/tb_store_checker.sv
// Directed bench for store_checker: verdicts, timeout race, log scoreboard,
// overflow, clear priority and asynchronous reset.
module tb_store_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;
    logic        log_rd = 1'b0;
    logic        done, pass, fail, timeout;
    logic [15:0] store_cnt;
    logic [31:0] fail_adr, fail_data;
    logic        log_valid, log_ovf;
    logic [31:0] log_adr, log_data;

    int checks = 0;
    int failures = 0;
    logic [63:0] sb[$];

    store_checker #(
        .PASS_ADDR (32'd84),
        .PASS_DATA (32'd7),
        .ALLOW_ADDR(32'd80),
        .TIMEOUT   (16),
        .LOG_DEPTH (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .memwrite (memwrite),
        .dataadr  (dataadr),
        .writedata(writedata),
        .done     (done),
        .pass     (pass),
        .fail     (fail),
        .timeout  (timeout),
        .store_cnt(store_cnt),
        .fail_adr (fail_adr),
        .fail_data(fail_data),
        .log_rd   (log_rd),
        .log_valid(log_valid),
        .log_adr  (log_adr),
        .log_data (log_data),
        .log_ovf  (log_ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives one edge worth of inputs; outputs are sampled 1 time unit after the edge.
    task automatic applyStimulus(input logic mw, input logic [31:0] adr, input logic [31:0] dat,
                                 input logic rd, input logic cl);
        memwrite  = mw;
        dataadr   = adr;
        writedata = dat;
        log_rd    = rd;
        clr       = cl;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
        dataadr   = '0;
        writedata = '0;
        log_rd    = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic storeLogged(input logic [31:0] adr, input logic [31:0] dat);
        sb.push_back({adr, dat});
        applyStimulus(1'b1, adr, dat, 1'b0, 1'b0);
    endtask

    task automatic popCheck(input string tag);
        logic [63:0] exp;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("[TB] FAIL %s scoreboard empty observed_valid=%b expected_valid=0", tag, log_valid);
        end else begin
            exp = sb.pop_front();
            checkOutput({tag, "_valid"}, 32'(log_valid), 32'd1);
            checkOutput({tag, "_adr"}, log_adr, exp[63:32]);
            checkOutput({tag, "_data"}, log_data, exp[31:0]);
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #2;
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_pass", 32'(pass), 32'd0);
        checkOutput("rst_fail", 32'(fail), 32'd0);
        checkOutput("rst_timeout", 32'(timeout), 32'd0);
        checkOutput("rst_log_valid", 32'(log_valid), 32'd0);
        checkOutput("rst_log_ovf", 32'(log_ovf), 32'd0);
        checkOutput("rst_store_cnt", 32'(store_cnt), 32'd0);
        checkOutput("rst_fail_adr", fail_adr, 32'd0);
        checkOutput("rst_log_adr", log_adr, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        $display("[TB] timeout with no stores");
        idle(15);
        checkOutput("tmo_edge15", 32'(timeout), 32'd0);
        idle(1);
        checkOutput("tmo_edge16", 32'(timeout), 32'd1);
        checkOutput("tmo_done", 32'(done), 32'd1);
        applyStimulus(1'b1, 32'd80, 32'd1, 1'b0, 1'b0);
        checkOutput("tmo_ignore_cnt", 32'(store_cnt), 32'd0);
        checkOutput("tmo_ignore_log", 32'(log_valid), 32'd0);

        $display("[TB] pass store on the timeout edge");
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("clr_timeout", 32'(timeout), 32'd0);
        idle(15);
        storeLogged(32'd84, 32'd7);
        checkOutput("race_pass", 32'(pass), 32'd1);
        checkOutput("race_timeout", 32'(timeout), 32'd0);
        checkOutput("race_cnt", 32'(store_cnt), 32'd1);
        popCheck("race_log0");
        checkOutput("race_log_empty", 32'(log_valid), 32'd0);

        $display("[TB] allowed stores then pass");
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        storeLogged(32'd80, 32'h11);
        storeLogged(32'd80, 32'h22);
        checkOutput("allow_done", 32'(done), 32'd0);
        storeLogged(32'd84, 32'd7);
        checkOutput("seq_pass", 32'(pass), 32'd1);
        checkOutput("seq_fail", 32'(fail), 32'd0);
        checkOutput("seq_cnt", 32'(store_cnt), 32'd3);
        applyStimulus(1'b1, 32'd88, 32'd9, 1'b0, 1'b0);
        checkOutput("seq_ignore_cnt", 32'(store_cnt), 32'd3);
        checkOutput("seq_ignore_pass", 32'(pass), 32'd1);
        popCheck("seq_log0");
        popCheck("seq_log1");
        popCheck("seq_log2");
        checkOutput("seq_log_empty", 32'(log_valid), 32'd0);

        $display("[TB] illegal stores");
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        storeLogged(32'd84, 32'd6);
        checkOutput("bad_data_fail", 32'(fail), 32'd1);
        checkOutput("bad_data_adr", fail_adr, 32'd84);
        checkOutput("bad_data_data", fail_data, 32'd6);
        checkOutput("bad_data_cnt", 32'(store_cnt), 32'd1);
        sb.delete();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("clr_fail", 32'(fail), 32'd0);
        checkOutput("clr_fail_adr", fail_adr, 32'd0);
        checkOutput("clr_cnt", 32'(store_cnt), 32'd0);
        checkOutput("clr_log", 32'(log_valid), 32'd0);
        storeLogged(32'd88, 32'd7);
        checkOutput("bad_adr_fail", 32'(fail), 32'd1);
        checkOutput("bad_adr_adr", fail_adr, 32'd88);
        checkOutput("bad_adr_data", fail_data, 32'd7);
        sb.delete();

        $display("[TB] log overflow");
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        for (int n = 0; n < 8; n++)
            storeLogged(32'd80, 32'(n));
        checkOutput("full_no_ovf", 32'(log_ovf), 32'd0);
        applyStimulus(1'b1, 32'd80, 32'd8, 1'b0, 1'b0);
        checkOutput("ovf_set", 32'(log_ovf), 32'd1);
        checkOutput("ovf_cnt", 32'(store_cnt), 32'd9);
        for (int n = 0; n < 8; n++)
            popCheck($sformatf("ovf_log%0d", n));
        checkOutput("ovf_drained", 32'(log_valid), 32'd0);

        $display("[TB] push and pop on a full log");
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("clr_ovf", 32'(log_ovf), 32'd0);
        for (int n = 0; n < 8; n++)
            storeLogged(32'd80, 32'h100 + 32'(n));
        checkOutput("pp_head_adr", log_adr, sb[0][63:32]);
        checkOutput("pp_head_data", log_data, sb[0][31:0]);
        void'(sb.pop_front());
        sb.push_back({32'd80, 32'h200});
        applyStimulus(1'b1, 32'd80, 32'h200, 1'b1, 1'b0);
        checkOutput("pp_no_ovf", 32'(log_ovf), 32'd0);
        for (int n = 0; n < 8; n++)
            popCheck($sformatf("pp_log%0d", n));
        checkOutput("pp_drained", 32'(log_valid), 32'd0);

        $display("[TB] clear beats a pass store");
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        storeLogged(32'd80, 32'd1);
        checkOutput("pre_clr_cnt", 32'(store_cnt), 32'd1);
        sb.delete();
        applyStimulus(1'b1, 32'd84, 32'd7, 1'b0, 1'b1);
        checkOutput("clr_race_pass", 32'(pass), 32'd0);
        checkOutput("clr_race_done", 32'(done), 32'd0);
        checkOutput("clr_race_cnt", 32'(store_cnt), 32'd0);
        checkOutput("clr_race_log", 32'(log_valid), 32'd0);

        $display("[TB] asynchronous reset mid-verdict");
        storeLogged(32'd80, 32'd3);
        storeLogged(32'd84, 32'd6);
        checkOutput("pre_rst_fail", 32'(fail), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst_fail", 32'(fail), 32'd0);
        checkOutput("arst_done", 32'(done), 32'd0);
        checkOutput("arst_fail_adr", fail_adr, 32'd0);
        checkOutput("arst_fail_data", fail_data, 32'd0);
        checkOutput("arst_cnt", 32'(store_cnt), 32'd0);
        checkOutput("arst_log_valid", 32'(log_valid), 32'd0);
        checkOutput("arst_log_adr", log_adr, 32'd0);
        sb.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_checker.md
# store_checker

Synthesizable end-of-test monitor that consumes the CPU top-level data-memory write bus (memwrite, dataadr, writedata). It classifies each store as pass, allowed or illegal, sets a sticky verdict, bounds the run with a cycle timeout, and keeps a small FIFO log of store traffic for post-mortem readout. It sits directly downstream of the CPU top, in parallel with data memory, so self-checking runs on FPGA without a simulator.

## Interface
- PASS_ADDR, 32'd84: store address that ends the test when paired with PASS_DATA
- PASS_DATA, 32'd7: write data required at PASS_ADDR for a pass
- ALLOW_ADDR, 32'd80: only address other than PASS_ADDR that may be stored to without failing
- TIMEOUT, 1024: cycles in RUN before a timeout verdict (≥2)
- LOG_DEPTH, 8: store-log FIFO entries (power of 2, ≥2)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous clear: restart run, flush log
- memwrite  in  1  store strobe from CPU top
- dataadr  in  32  store address
- writedata  in  32  store data
- done  out  1  verdict reached (state ≠ RUN)
- pass  out  1  state PASS
- fail  out  1  state FAIL
- timeout  out  1  state TMO
- store_cnt  out  16  stores seen in RUN, saturating at 16'hFFFF
- fail_adr  out  32  address of the illegal store
- fail_data  out  32  data of the illegal store
- log_rd  in  1  pop log head
- log_valid  out  1  log non-empty
- log_adr  out  32  head entry address (show-ahead)
- log_data  out  32  head entry data (show-ahead)
- log_ovf  out  1  sticky: a store was dropped because log was full

## Operation
- States: RUN, PASS, FAIL, TMO. Reset and clr enter RUN.
- RUN, memwrite=1 sampled at edge: dataadr==PASS_ADDR and writedata==PASS_DATA -> PASS; else dataadr==ALLOW_ADDR (any data) -> stay RUN; else -> FAIL, capture fail_adr/fail_data.
- PASS_ADDR with wrong data is illegal -> FAIL.
- RUN cycle counter counts every edge in RUN; when it reaches TIMEOUT-1 with no terminal store that edge -> TMO.
- Store and timeout on same edge: store classification wins (PASS or FAIL, not TMO).
- PASS/FAIL/TMO sticky; memwrite ignored (no count, no log, no capture) until clr or reset.
- store_cnt increments on every store classified in RUN, including the terminating one; saturates.
- Log: every store classified in RUN is pushed {dataadr, writedata}. log_rd with log_valid pops head; log_rd when empty ignored.
- Full log: push without pop drops the new entry and sets log_ovf; push with pop same edge performs both, no overflow.
- Log readout remains functional in all states.
- clr has priority over memwrite on the same edge: store ignored; counter, store_cnt, fail_adr, fail_data, log_ovf zeroed; log emptied.

## Timing
- Reset values: state RUN; done, pass, fail, timeout, log_valid, log_ovf = 0; store_cnt, fail_adr, fail_data, log_adr, log_data = 0.
- Reset mid-run or mid-verdict: immediate asynchronous return to reset values, log emptied.
- Verdict latency: one cycle; done/pass/fail/timeout registered, high after the edge that sampled the terminating store.
- fail_adr/fail_data valid on the same cycle fail rises.
- Timeout: with no stores, timeout rises TIMEOUT cycles after rst deassertion or clr.
- Log: pushed entry visible on log_adr/log_data after the push edge if log was empty; log_valid falls the edge the last entry pops.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Stores (80,x), (80,y), then (84,7) -> pass=1 one cycle later, store_cnt=3, log holds three entries in order, later memwrite ignored.
- Store (84,6) -> fail=1, fail_adr=84, fail_data=6; store (88,7) after clr -> fail, fail_adr=88.
- TIMEOUT=16, no stores -> timeout=1 exactly 16 cycles after rst release; (84,7) on edge 16 -> pass, not timeout.
- LOG_DEPTH=8: nine (80,n) stores without reads -> log_ovf=1, eight entries n=0..7 read back; full log with simultaneous push+pop -> no overflow.
- clr and (84,7) on same edge -> state RUN, store_cnt=0, log empty; rst pulsed low mid-run -> all outputs to reset values immediately.
